dma_master_mc: RTL and testbench
================================

DMA_MASTER_MC -- requirements
Module: dma_master_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent DMA channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning read-to-write buffer depth in words (power of 2, >=2).
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning maximum beats per AXI burst (1..256).
REQ-004 SHALL have parameter DMA_ID, default 4'h1, meaning value driven on arid/awid.
REQ-005 SHALL have ports: clk input 1, the single clock; rst input 1, the reset, synchronous and active-high.
REQ-006 SHALL have ports: ch_start_i input NUM_CH, per-channel start pulse; ch_src_i input NUM_CH*32, source byte address; ch_dst_i input NUM_CH*32, destination byte address; ch_qty_i input NUM_CH*32, transfer length in 32-bit words.
REQ-007 SHALL have ports: ch_busy_o output NUM_CH, channel active; ch_fin_o output NUM_CH, one-cycle done pulse; ch_err_o output NUM_CH, sticky error flag, cleared by the next start.
REQ-008 SHALL have AR ports: arvalid output 1; arready input 1; araddr output 32; arlen output 8; arsize output 3; arburst output 2; arid output 4.
REQ-009 SHALL have R ports: rvalid input 1; rready output 1; rdata input 32; rlast input 1; rresp input 2.
REQ-010 SHALL have AW ports: awvalid output 1; awready input 1; awaddr output 32; awlen output 8; awsize output 3; awburst output 2; awid output 4.
REQ-011 SHALL have W/B ports: wvalid output 1; wready input 1; wdata output 32; wstrb output 4; wlast output 1; bvalid input 1; bready output 1; bresp input 2.

Function
REQ-012 SHALL latch src/dst/qty of channel k on ch_start_i[k] only while ch_busy_o[k]=0; a start on a busy channel SHALL be ignored.
REQ-013 SHALL treat qty=0 as immediate completion: ch_fin_o[k] pulses the cycle after start, no AXI traffic, busy never set.
REQ-014 SHALL use engine states IDLE, ARB, AR, AW, DATA, RESP: IDLE->ARB when any channel has remaining words; ARB->AR (1 cycle); AR->AW on arvalid&arready; AW->DATA on awvalid&awready; DATA->RESP on final W beat accepted; RESP->ARB on bvalid&bready.
REQ-015 SHALL grant one channel per burst by round-robin in ARB, priority starting at the channel after the last grant; simultaneous starts SHALL be served in that order, interleaved at burst granularity.
REQ-016 SHALL size each burst as len = min(remaining, MAX_LEN); arlen = awlen = len-1; arsize = awsize = 3'b010; arburst = awburst = INCR (2'b01); wstrb = 4'hF.
REQ-017 SHALL, on RESP exit, advance the granted channel's src and dst by len*4 (32-bit wrap-around, no carry-out) and reduce remaining by len.
REQ-018 SHALL drive arvalid only in AR, awvalid only in AW, bready only in RESP; held valids SHALL keep address/len stable until handshake.
REQ-019 SHALL drive rready = (state==DATA) & ~fifo_full; push rdata on rvalid&rready; wvalid = (state==DATA) & ~fifo_empty; pop on wvalid&wready.
REQ-020 SHALL support simultaneous FIFO push and pop in one cycle with occupancy unchanged; no push when full, no pop when empty.
REQ-021 SHALL assert wlast on the beat where the W beat counter equals len-1, independent of the read-side rlast.
REQ-022 SHALL accept at most len R beats per burst; additional rvalid SHALL not be acknowledged.
REQ-023 SHALL set ch_err_o[k] when rresp or bresp is nonzero for channel k's burst; after RESP the channel SHALL abort (remaining cleared), pulse ch_fin_o[k], clear busy.
REQ-024 SHALL pulse ch_fin_o[k] one cycle after the RESP handshake that brings remaining to zero, with busy deasserting the same cycle.
REQ-025 SHALL reach ARB no sooner than 1 cycle after RESP, so minimum inter-burst gap is 2 cycles.

Reset
REQ-026 SHALL, on rst high at a clock edge, go to IDLE, empty the FIFO, clear all channel registers, and drive every valid/ready/fin/busy/err output to 0 on the next cycle, including mid-burst.
REQ-027 SHALL drive araddr/awaddr/arlen/awlen/wdata to 0 after reset.

Verification
REQ-028 Ch0 start src=0x1000 dst=0x2000 qty=20, MAX_LEN=16, zero-wait slave -> bursts len 16 then 4 (arlen 15, 3), second at 0x1040/0x2040, ch_fin_o[0] one pulse, data copied.
REQ-029 Ch0 qty=8 and ch1 qty=8 started same cycle -> ch0 burst granted first, then ch1; each fin pulses once.
REQ-030 wready low 10 cycles mid-burst, FIFO_DEPTH=4 -> exactly 4 words buffered, rready deasserts, no data lost or duplicated.
REQ-031 bresp=2'b10 on ch1 first burst of qty=40 -> ch_err_o[1]=1, no further ch1 bursts, ch_fin_o[1] pulses.
REQ-032 rst asserted during DATA of a 16-beat burst -> next cycle all valids 0, busy 0; new start afterward completes normally.
REQ-033 Start qty=0 on ch0 and re-start ch0 while busy -> immediate fin pulse, no AXI traffic; busy-time start ignored.

Source files
------------

// File: rtl/dma_master_mc.sv
// Multi-channel AXI DMA master: round-robin burst engine copying words from src to dst
// through a small read-to-write FIFO, one outstanding burst at a time.
module dma_master_mc #(
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_LEN    = 16,
  parameter logic [3:0]  DMA_ID     = 4'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_start_i,
  input  logic [NUM_CH*32-1:0] ch_src_i,
  input  logic [NUM_CH*32-1:0] ch_dst_i,
  input  logic [NUM_CH*32-1:0] ch_qty_i,
  output logic [NUM_CH-1:0]    ch_busy_o,
  output logic [NUM_CH-1:0]    ch_fin_o,
  output logic [NUM_CH-1:0]    ch_err_o,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [31:0]          araddr,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [3:0]           arid,
  input  logic                 rvalid,
  output logic                 rready,
  input  logic [31:0]          rdata,
  input  logic                 rlast,
  input  logic [1:0]           rresp,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          awaddr,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic [3:0]           awid,
  output logic                 wvalid,
  input  logic                 wready,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  input  logic                 bvalid,
  output logic                 bready,
  input  logic [1:0]           bresp
);

  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FAW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_AR, S_AW, S_DATA, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        src_q [NUM_CH];
  logic [31:0]        dst_q [NUM_CH];
  logic [31:0]        rem_q [NUM_CH];
  logic [NUM_CH-1:0]  busy_q, fin_q, err_q;
  logic [CW-1:0]      grant_q, last_q, pick;
  logic               pick_vld;
  logic [CW:0]        idx;
  logic [8:0]         len_q, rcnt_q, wcnt_q, next_len;
  logic               burst_err_q;
  logic [31:0]        araddr_q, awaddr_q;
  logic [7:0]         axlen_q;
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [FAW:0]       wr_ptr_q, rd_ptr_q;
  logic               fifo_full, fifo_empty, r_push, w_pop, resp_hs, resp_err;
  logic [31:0]        len_bytes;

  // Round-robin: scan starting at the channel after the last grant.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, last_q} + (CW+1)'(i + 1);
      if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
      if (!pick_vld && rem_q[idx[CW-1:0]] != 32'd0) begin
        pick_vld = 1'b1;
        pick     = idx[CW-1:0];
      end
    end
  end

  assign next_len   = (rem_q[pick] > 32'(MAX_LEN)) ? 9'(MAX_LEN) : rem_q[pick][8:0];
  assign len_bytes  = {21'b0, len_q, 2'b00};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                      (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);

  assign rready   = (state_q == S_DATA) && !fifo_full && (rcnt_q < len_q);
  assign wvalid   = (state_q == S_DATA) && !fifo_empty;
  assign wlast    = wvalid && (wcnt_q == len_q - 9'd1);
  assign wdata    = wvalid ? fifo_mem[rd_ptr_q[FAW-1:0]] : 32'd0;
  assign r_push   = rvalid && rready;
  assign w_pop    = wvalid && wready;
  assign resp_hs  = (state_q == S_RESP) && bvalid;
  assign resp_err = burst_err_q || (bresp != 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pick_vld) state_d = S_ARB;
      S_ARB:  state_d = pick_vld ? S_AR : S_IDLE;
      S_AR:   if (arready) state_d = S_AW;
      S_AW:   if (awready) state_d = S_DATA;
      S_DATA: if (w_pop && wlast) state_d = S_RESP;
      S_RESP: if (bvalid) state_d = S_ARB;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races.
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= CW'(NUM_CH - 1);
      len_q       <= '0;
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      burst_err_q <= 1'b0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      axlen_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ARB && pick_vld) begin
        grant_q     <= pick;
        last_q      <= pick;
        len_q       <= next_len;
        araddr_q    <= src_q[pick];
        awaddr_q    <= dst_q[pick];
        axlen_q     <= 8'(next_len - 9'd1);
        rcnt_q      <= '0;
        wcnt_q      <= '0;
        burst_err_q <= 1'b0;
      end
      if (r_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        rcnt_q   <= rcnt_q + 9'd1;
        if (rresp != 2'b00) burst_err_q <= 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        wcnt_q   <= wcnt_q + 9'd1;
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (r_push) fifo_mem[wr_ptr_q[FAW-1:0]] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        src_q[k] <= '0;
        dst_q[k] <= '0;
        rem_q[k] <= '0;
      end
      busy_q <= '0;
      fin_q  <= '0;
      err_q  <= '0;
    end else begin
      fin_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_start_i[k] && !busy_q[k]) begin
          src_q[k] <= ch_src_i[k*32 +: 32];
          dst_q[k] <= ch_dst_i[k*32 +: 32];
          rem_q[k] <= ch_qty_i[k*32 +: 32];
          err_q[k] <= 1'b0;
          if (ch_qty_i[k*32 +: 32] == 32'd0) fin_q[k]  <= 1'b1;
          else                               busy_q[k] <= 1'b1;
        end
      end
      // A granted channel is busy, so its start input cannot collide with this update.
      if (resp_hs) begin
        if (resp_err) begin
          rem_q[grant_q]  <= '0;
          err_q[grant_q]  <= 1'b1;
          fin_q[grant_q]  <= 1'b1;
          busy_q[grant_q] <= 1'b0;
        end else begin
          src_q[grant_q] <= src_q[grant_q] + len_bytes;
          dst_q[grant_q] <= dst_q[grant_q] + len_bytes;
          rem_q[grant_q] <= rem_q[grant_q] - 32'(len_q);
          if (rem_q[grant_q] == 32'(len_q)) begin
            fin_q[grant_q]  <= 1'b1;
            busy_q[grant_q] <= 1'b0;
          end
        end
      end
    end
  end

  assign ch_busy_o = busy_q;
  assign ch_fin_o  = fin_q;
  assign ch_err_o  = err_q;
  assign arvalid   = (state_q == S_AR);
  assign awvalid   = (state_q == S_AW);
  assign bready    = (state_q == S_RESP);
  assign araddr    = araddr_q;
  assign awaddr    = awaddr_q;
  assign arlen     = axlen_q;
  assign awlen     = axlen_q;
  assign arsize    = 3'b010;
  assign awsize    = 3'b010;
  assign arburst   = 2'b01;
  assign awburst   = 2'b01;
  assign arid      = DMA_ID;
  assign awid      = DMA_ID;
  assign wstrb     = 4'hF;

endmodule

// File: tb/tb_dma_master_mc.sv
// Directed bench for dma_master_mc with a zero-wait AXI slave model (stallable W, injectable bresp).
module tb_dma_master_mc;

  logic        clk, rst;
  logic [1:0]  ch_start_i, ch_busy_o, ch_fin_o, ch_err_o;
  logic [63:0] ch_src_i, ch_dst_i, ch_qty_i;
  logic        arvalid, arready, rvalid, rready, rlast, awvalid, awready;
  logic        wvalid, wready, wlast, bvalid, bready;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  arid, awid, wstrb;

  dma_master_mc dut (
    .clk(clk), .rst(rst),
    .ch_start_i(ch_start_i), .ch_src_i(ch_src_i), .ch_dst_i(ch_dst_i), .ch_qty_i(ch_qty_i),
    .ch_busy_o(ch_busy_o), .ch_fin_o(ch_fin_o), .ch_err_o(ch_err_o),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rq_addr [$];
  int          rq_len  [$];
  logic [31:0] ar_addr_log [$];
  int          ar_len_log  [$];
  logic [31:0] aw_addr_log [$];
  int          aw_len_log  [$];
  logic [31:0] wmem [logic [31:0]];
  logic [31:0] r_addr, w_addr;
  int  r_left, w_len, w_idx;
  bit  b_pend;
  int  b_cnt, r_cnt, w_cnt, wlast_err, side_err, fin_busy_err;
  int  fin_cnt [2];
  int  err_b_idx;
  bit  w_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] ar_a(input int i);
    return (i < ar_addr_log.size()) ? ar_addr_log[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic int ar_l(input int i);
    return (i < ar_len_log.size()) ? ar_len_log[i] : -1;
  endfunction
  function automatic logic [31:0] aw_a(input int i);
    return (i < aw_addr_log.size()) ? aw_addr_log[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic int aw_l(input int i);
    return (i < aw_len_log.size()) ? aw_len_log[i] : -1;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Slave model: outputs change on negedge; handshakes seen here complete at the next posedge.
  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0;
    bvalid = 0; bresp = 0; r_left = 0; w_len = 0; w_idx = 0; b_pend = 0;
    b_cnt = 0; r_cnt = 0; w_cnt = 0; wlast_err = 0; side_err = 0; fin_busy_err = 0;
    fin_cnt[0] = 0; fin_cnt[1] = 0; r_addr = 0; w_addr = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ch_fin_o[k]) fin_cnt[k]++;
        if (ch_fin_o[k] && ch_busy_o[k]) fin_busy_err++;
      end
      if (rst) begin
        rq_addr.delete(); rq_len.delete();
        r_left = 0; b_pend = 0; w_len = 0; w_idx = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; rdata = 0; rlast = 0; bvalid = 0; bresp = 0;
      end else begin
        arready = 1; awready = 1; wready = !w_stall;
        if (r_left == 0 && rq_addr.size() > 0) begin
          r_addr = rq_addr.pop_front();
          r_left = rq_len.pop_front();
        end
        rvalid = (r_left != 0);
        rdata  = rvalid ? pat(r_addr) : 32'd0;
        rlast  = (r_left == 1);
        rresp  = 2'b00;
        bvalid = b_pend;
        bresp  = (b_pend && b_cnt == err_b_idx) ? 2'b10 : 2'b00;
        if (arvalid && arready) begin
          rq_addr.push_back(araddr); rq_len.push_back(int'(arlen) + 1);
          ar_addr_log.push_back(araddr); ar_len_log.push_back(int'(arlen));
          if (arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'h1) side_err++;
        end
        if (rvalid && rready) begin
          r_cnt++; r_addr += 4; r_left--;
        end
        if (awvalid && awready) begin
          w_addr = awaddr; w_len = int'(awlen) + 1; w_idx = 0;
          aw_addr_log.push_back(awaddr); aw_len_log.push_back(int'(awlen));
          if (awsize !== 3'b010 || awburst !== 2'b01 || awid !== 4'h1) side_err++;
        end
        if (wvalid && wready) begin
          wmem[w_addr] = wdata;
          if (wlast !== (w_idx == w_len - 1)) wlast_err++;
          if (wstrb !== 4'hF) side_err++;
          w_idx++; w_addr += 4; w_cnt++;
          if (wlast) b_pend = 1;
        end
        if (bvalid && bready) begin
          b_pend = 0; b_cnt++;
        end
      end
    end
  end

  task automatic set_ch(input int k, input logic [31:0] src, input logic [31:0] dst,
                        input logic [31:0] qty);
    ch_start_i[k]       = 1'b1;
    ch_src_i[k*32 +: 32] = src;
    ch_dst_i[k*32 +: 32] = dst;
    ch_qty_i[k*32 +: 32] = qty;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    ch_start_i = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fin(input string tag, input int k, input int target);
    int n = 0;
    while (fin_cnt[k] < target && n < 400) begin
      step(1); n++;
    end
    step(2);
    check(tag, fin_cnt[k], target);
  endtask

  task automatic check_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int n);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = dst + 32'(4 * i);
      if (!wmem.exists(a) || wmem[a] !== pat(src + 32'(4 * i))) errs++;
    end
    check(tag, errs, 0);
  endtask

  initial begin
    int base, f0, f1, r0, w0, n;
    rst = 1; ch_start_i = '0; ch_src_i = '0; ch_dst_i = '0; ch_qty_i = '0;
    w_stall = 0; err_b_idx = -1;
    step(3);
    check("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 0);
    check("rst_busy_fin_err", 32'({ch_busy_o, ch_fin_o, ch_err_o}), 0);
    check("rst_addr", araddr | awaddr | wdata, 0);
    check("rst_len", 32'({arlen, awlen}), 0);
    rst = 0;
    step(1);

    // Simultaneous starts: ch0 granted first after reset, then ch1.
    base = ar_addr_log.size(); f0 = fin_cnt[0]; f1 = fin_cnt[1];
    set_ch(0, 32'h3000, 32'h4000, 8);
    set_ch(1, 32'h5000, 32'h6000, 8);
    pulse_start();
    check("rr_busy", 32'(ch_busy_o), 32'h3);
    wait_fin("rr_fin0", 0, f0 + 1);
    wait_fin("rr_fin1", 1, f1 + 1);
    check("rr_ar0", ar_a(base), 32'h3000);
    check("rr_ar1", ar_a(base + 1), 32'h5000);
    check("rr_len", 32'(ar_l(base) + ar_l(base + 1)), 14);
    check_copy("rr_copy0", 32'h3000, 32'h4000, 8);
    check_copy("rr_copy1", 32'h5000, 32'h6000, 8);

    // Single channel, qty 20 -> bursts of 16 then 4.
    base = ar_addr_log.size(); f0 = fin_cnt[0];
    set_ch(0, 32'h1000, 32'h2000, 20);
    pulse_start();
    wait_fin("q20_fin", 0, f0 + 1);
    check("q20_nbursts", ar_addr_log.size() - base, 2);
    check("q20_ar0", ar_a(base), 32'h1000);
    check("q20_arlen0", ar_l(base), 15);
    check("q20_ar1", ar_a(base + 1), 32'h1040);
    check("q20_arlen1", ar_l(base + 1), 3);
    check("q20_aw0", aw_a(base), 32'h2000);
    check("q20_aw1", aw_a(base + 1), 32'h2040);
    check("q20_awlen1", aw_l(base + 1), 3);
    check("q20_word0", wmem.exists(32'h2000) ? wmem[32'h2000] : 32'h0, 32'hDEAD1000);
    check("q20_word19", wmem.exists(32'h204C) ? wmem[32'h204C] : 32'h0, 32'hDEAD104C);
    check_copy("q20_copy", 32'h1000, 32'h2000, 20);
    check("q20_idle", 32'({ch_busy_o, ch_err_o}), 0);

    // Interleave at burst granularity; last grant was ch0 so ch1 leads.
    base = ar_addr_log.size(); f0 = fin_cnt[0]; f1 = fin_cnt[1];
    set_ch(0, 32'h2_0000, 32'h3_0000, 20);
    set_ch(1, 32'h4_0000, 32'h5_0000, 20);
    pulse_start();
    wait_fin("il_fin0", 0, f0 + 1);
    check("il_fin1", fin_cnt[1], f1 + 1);
    check("il_ar0", ar_a(base), 32'h4_0000);
    check("il_ar1", ar_a(base + 1), 32'h2_0000);
    check("il_ar2", ar_a(base + 2), 32'h4_0040);
    check("il_ar3", ar_a(base + 3), 32'h2_0040);
    check_copy("il_copy0", 32'h2_0000, 32'h3_0000, 20);
    check_copy("il_copy1", 32'h4_0000, 32'h5_0000, 20);

    // W back-pressure: FIFO fills to its depth and rready drops.
    f0 = fin_cnt[0]; r0 = r_cnt; w0 = w_cnt; n = 0;
    set_ch(0, 32'h8000, 32'h9000, 16);
    pulse_start();
    while (w_cnt < w0 + 2 && n < 100) begin step(1); n++; end
    w_stall = 1;
    step(10);
    check("bp_buffered", (r_cnt - r0) - (w_cnt - w0), 4);
    check("bp_rready", 32'(rready), 0);
    w_stall = 0;
    wait_fin("bp_fin", 0, f0 + 1);
    check("bp_rbeats", r_cnt - r0, 16);
    check("bp_wbeats", w_cnt - w0, 16);
    check_copy("bp_copy", 32'h8000, 32'h9000, 16);

    // bresp error on ch1's first burst aborts the channel.
    base = ar_addr_log.size(); f1 = fin_cnt[1];
    err_b_idx = b_cnt;
    set_ch(1, 32'h6_0000, 32'h7_0000, 40);
    pulse_start();
    wait_fin("err_fin", 1, f1 + 1);
    step(30);
    check("err_flag", 32'(ch_err_o), 32'h2);
    check("err_busy", 32'(ch_busy_o), 0);
    check("err_nbursts", ar_addr_log.size() - base, 1);
    check("err_ar0", ar_a(base), 32'h6_0000);
    set_ch(1, 32'h0, 32'h0, 0);
    pulse_start();
    check("err_cleared", 32'(ch_err_o), 0);

    // Reset in the middle of a 16-beat burst.
    w0 = w_cnt; n = 0;
    set_ch(0, 32'h8_0000, 32'h9_0000, 16);
    pulse_start();
    while (w_cnt < w0 + 3 && n < 100) begin step(1); n++; end
    rst = 1;
    step(1);
    check("mrst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 0);
    check("mrst_busy", 32'({ch_busy_o, ch_fin_o, ch_err_o}), 0);
    check("mrst_addr", araddr | awaddr | wdata | 32'(arlen), 0);
    rst = 0;
    step(1);
    base = ar_addr_log.size(); f0 = fin_cnt[0];
    set_ch(0, 32'hA_0000, 32'hB_0000, 4);
    pulse_start();
    wait_fin("mrst_fin", 0, f0 + 1);
    check("mrst_ar", ar_a(base), 32'hA_0000);
    check("mrst_len", ar_l(base), 3);
    check_copy("mrst_copy", 32'hA_0000, 32'hB_0000, 4);

    // qty=0 completes at once; a start on a busy channel is ignored.
    base = ar_addr_log.size(); f0 = fin_cnt[0];
    set_ch(0, 32'h5555_0000, 32'h6666_0000, 0);
    pulse_start();
    check("q0_fin", 32'(ch_fin_o), 32'h1);
    check("q0_busy", 32'(ch_busy_o), 0);
    step(1);
    check("q0_fin_width", 32'(ch_fin_o), 0);
    step(5);
    check("q0_no_axi", ar_addr_log.size() - base, 0);
    f0 = fin_cnt[0];
    set_ch(0, 32'hC_0000, 32'hD_0000, 8);
    pulse_start();
    check("ign_busy", 32'(ch_busy_o), 32'h1);
    set_ch(0, 32'hE_0000, 32'hF_0000, 4);
    pulse_start();
    wait_fin("ign_fin", 0, f0 + 1);
    step(20);
    check("ign_fin_once", fin_cnt[0], f0 + 1);
    check("ign_nbursts", ar_addr_log.size() - base, 1);
    check("ign_ar", ar_a(base), 32'hC_0000);
    check_copy("ign_copy", 32'hC_0000, 32'hD_0000, 8);

    check("wlast_errors", wlast_err, 0);
    check("sideband_errors", side_err, 0);
    check("fin_busy_overlap", fin_busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
